// File: rtl/acq_sequencer.sv
// Acquisition sequencer: gates a sample source in whole frames of M samples,
// forwards the returned samples with frame/sop/eop tags and reports completion.
module acq_sequencer #(
  parameter int M  = 32,
  parameter int Q  = 12,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [NW-1:0] n_frames,
  output logic          src_enable,
  input  logic          src_valid,
  input  logic [Q-1:0]  src_data,
  output logic          out_valid,
  output logic [Q-1:0]  out_data,
  output logic          out_sop,
  output logic          out_eop,
  output logic [NW-1:0] out_frame,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  localparam int IW = $clog2(M);
  localparam logic [IW-1:0] IDX_LAST = IW'(M - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          accept_s, last_issue_s, drained_s;
  logic [NW-1:0] nfr_r;
  logic          abort_pend_r;
  logic [IW-1:0] iss_idx_r, rx_idx_r;
  logic [NW-1:0] iss_frm_r, rx_frm_r;
  logic          src_enable_r, busy_r, done_r, aborted_r;
  logic          out_valid_r, out_sop_r, out_eop_r;
  logic [Q-1:0]  out_data_r;
  logic [NW-1:0] out_frame_r;

  // Next-state decode; RUN only ends on a frame boundary so the source phase is preserved
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    last_issue_s = (iss_idx_r == IDX_LAST) &&
                   ((iss_frm_r == (nfr_r - NW'(1))) || abort_pend_r);
    drained_s    = (rx_idx_r == iss_idx_r) && (rx_frm_r == iss_frm_r);
    case (state_r)
      IDLE: begin
        if (start && (n_frames != '0)) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_issue_s) state_s = DRAIN;
        else              state_s = RUN;
      end
      DRAIN: begin
        if (drained_s) state_s = FINISH;
        else           state_s = DRAIN;
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control registers: state, registered status flags, latched frame count, abort tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      src_enable_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      abort_pend_r <= 1'b0;
      nfr_r        <= '0;
    end else begin
      state_r      <= state_s;
      src_enable_r <= (state_s == RUN);
      busy_r       <= (state_s != IDLE);
      done_r       <= (state_s == FINISH);
      if (accept_s) begin
        nfr_r        <= n_frames;
        aborted_r    <= 1'b0;
        abort_pend_r <= 1'b0;
      end else if (state_s == FINISH) begin
        aborted_r    <= abort_pend_r;
        abort_pend_r <= 1'b0;
      end else if ((state_r == RUN) && abort && !last_issue_s) begin
        // an abort landing on the final issue is moot: the run ends normally there
        abort_pend_r <= 1'b1;
      end
    end
  end

  // Issue and receive position counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iss_idx_r <= '0;
      iss_frm_r <= '0;
      rx_idx_r  <= '0;
      rx_frm_r  <= '0;
    end else if (accept_s) begin
      iss_idx_r <= '0;
      iss_frm_r <= '0;
      rx_idx_r  <= '0;
      rx_frm_r  <= '0;
    end else begin
      if (src_enable_r) begin
        iss_idx_r <= iss_idx_r + IW'(1);
        if (iss_idx_r == IDX_LAST) iss_frm_r <= iss_frm_r + NW'(1);
      end
      if (src_valid && busy_r) begin
        rx_idx_r <= rx_idx_r + IW'(1);
        if (rx_idx_r == IDX_LAST) rx_frm_r <= rx_frm_r + NW'(1);
      end
    end
  end

  // Forwarding stage: one register between source and output, tags zero when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
      out_frame_r <= '0;
    end else if (src_valid && busy_r) begin
      out_valid_r <= 1'b1;
      out_data_r  <= src_data;
      out_sop_r   <= (rx_idx_r == '0);
      out_eop_r   <= (rx_idx_r == IDX_LAST);
      out_frame_r <= rx_frm_r;
    end else begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
      out_frame_r <= '0;
    end
  end

  assign src_enable = src_enable_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign aborted    = aborted_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_sop    = out_sop_r;
  assign out_eop    = out_eop_r;
  assign out_frame  = out_frame_r;

endmodule
